// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
// Optional packet framing is enabled with FIFO_READER_TLAST_EN.
package fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } rd_state_t;

   function automatic int unsigned ptr_next(
      input int unsigned p,
      input int unsigned depth
   );
      return (p >= depth - 32'd1) ? 32'd0 : p + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// Circular output buffer between the FIFO read port and the stream.
// A clear drops all entries; storage contents are left as they were.
module fifo_reader_obuf
   import fifo_reader_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH = 3,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 clr,
   input  logic [BIT_WIDTH-1:0] din,
   output logic [BIT_WIDTH-1:0] dout,
   output logic [CW-1:0]        count
);

   logic [BIT_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;

   assign dout = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // The credit check upstream must never let a push land on a full buffer.
         assert (!(push && count == CW'(DEPTH)));
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= PW'(ptr_next(32'(wr_ptr), DEPTH));
         end
         if (pop) rd_ptr <= PW'(ptr_next(32'(rd_ptr), DEPTH));
         if (push && !pop) count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads the FIFO and re-presents its words as a valid/ready stream.
// Define FIFO_READER_TLAST_EN to add PKT_LEN-beat framing on m_tlast.
module fifo_stream_reader
   import fifo_reader_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int BUF_DEPTH = 3,
   parameter int PKT_LEN = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 flush,
   output logic                 fifo_re,
   input  logic [BIT_WIDTH-1:0] fifo_dout,
   input  logic                 fifo_ovalid,
   input  logic                 fifo_empty,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [BIT_WIDTH-1:0] m_tdata,
`ifdef FIFO_READER_TLAST_EN
   output logic                 m_tlast,
`endif
   output logic                 busy,
   output logic                 flush_done
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   if (BIT_WIDTH < 1 || BUF_DEPTH < 1 || PKT_LEN < 1) begin : g_param_check
      $error("fifo_stream_reader: parameters must be >= 1");
   end

   rd_state_t     state;
   rd_state_t     state_nxt;
   logic          inflight;
   logic [CW-1:0] count;
   logic [CW:0]   used;
   logic          credit_ok;
   logic          push;
   logic          pop;

   // A read still in flight owns a buffer slot until it lands.
   assign used = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign credit_ok = used < (CW + 1)'(BUF_DEPTH);

   assign flush_done = (state == FLUSH) && fifo_empty && !inflight;
   assign push = fifo_ovalid && (state != FLUSH);
   assign pop = m_tvalid && m_tready;
   assign m_tvalid = count != '0;
   assign busy = (state != IDLE) || m_tvalid;

   always_comb begin
      fifo_re = 1'b0;
      unique case (state)
         RUN:     fifo_re = !fifo_empty && credit_ok;
         FLUSH:   fifo_re = !fifo_empty;
         default: fifo_re = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = FLUSH;
      end else begin
         unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_re;
      end
   end

   fifo_reader_obuf #(
      .BIT_WIDTH(BIT_WIDTH),
      .DEPTH(BUF_DEPTH)
   ) u_obuf (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .pop(pop),
      .clr(flush),
      .din(fifo_dout),
      .dout(m_tdata),
      .count(count)
   );

`ifdef FIFO_READER_TLAST_EN
   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   logic [BW-1:0] beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat <= '0;
      else if (flush) beat <= '0;
      else if (pop) beat <= BW'(ptr_next(32'(beat), PKT_LEN));
   end

   assign m_tlast = m_tvalid && (beat == BW'(PKT_LEN - 1));
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and a stream scoreboard.
// Define FIFO_READER_TLAST_EN to also exercise packet framing.
module tb_fifo_stream_reader;

   localparam int BW = 16;
   localparam int DEPTH = 3;
   localparam int PKT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic flush = 1'b0;
   logic m_tready = 1'b0;
   logic fifo_re;
   logic fifo_empty;
   logic m_tvalid;
   logic busy;
   logic flush_done;
   logic [BW-1:0] m_tdata;
   logic [BW-1:0] f_dout = '0;
   logic f_ovalid = 1'b0;
`ifdef FIFO_READER_TLAST_EN
   logic m_tlast;
   int last_idx[$];
`endif

   logic [BW-1:0] fmem [256];
   int fr = 0;
   int fw = 0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int max_occ = 0;
   int beat = 0;
   bit flushing = 1'b0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] out_log[$];
   int out_cyc[$];

   always #5 clk = ~clk;

   assign fifo_empty = (fr == fw);

   fifo_stream_reader #(
      .BIT_WIDTH(BW),
      .BUF_DEPTH(DEPTH),
      .PKT_LEN(PKT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .flush(flush),
      .fifo_re(fifo_re),
      .fifo_dout(f_dout),
      .fifo_ovalid(f_ovalid),
      .fifo_empty(fifo_empty),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tdata(m_tdata),
`ifdef FIFO_READER_TLAST_EN
      .m_tlast(m_tlast),
`endif
      .busy(busy),
      .flush_done(flush_done)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // FIFO with one clock of read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      f_ovalid <= fifo_re && !fifo_empty;
      if (fifo_re && !fifo_empty) begin
         f_dout <= fmem[8'(fr)];
         fr <= fr + 1;
      end
   end

   // Expected stream: every word the FIFO returns, in order, minus flushed ones
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         flushing = 1'b0;
         beat = 0;
      end else begin
         if (m_tvalid && m_tready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            beat = beat + 1;
         end
         if (f_ovalid && !flushing) exp_q.push_back(f_dout);
         if (flush_done) flushing = 1'b0;
         if (flush) begin
            exp_q.delete();
            flushing = 1'b1;
            beat = 0;
         end
         if (exp_q.size() > max_occ) max_occ = exp_q.size();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) chk("tdata", 32'(m_tdata), 32'(exp_q[0]));
`ifdef FIFO_READER_TLAST_EN
         chk("tlast", 32'(m_tlast),
             32'(exp_q.size() != 0 && (beat % PKT) == PKT - 1));
         if (m_tvalid && m_tready && m_tlast) last_idx.push_back(beat);
`endif
         if (m_tvalid && m_tready) begin
            out_log.push_back(m_tdata);
            out_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         fmem[8'(fw)] = BW'(base + i);
         fw++;
      end
   endtask

   task automatic wait_out(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (out_log.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      checks++;
      if (out_log.size() < n) begin
         errors++;
         $display("FAIL %s timeout: got %0d beats expected %0d",
                  name, out_log.size(), n);
      end
   endtask

   task automatic chk_log(input string name, input int base, input int first,
                          input int n);
      for (int i = 0; i < n; i++) begin
         if (base + i < out_log.size())
            chk(name, 32'(out_log[base + i]), 32'(first + i));
         else
            chk(name, 32'hdead, 32'(first + i));
      end
   endtask

   initial begin
      int base;
      int rbase;
      int k;
      bit seen;

      tick(2);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_fifo_re", 32'(fifo_re), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      rst_n = 1'b1;

      // 1: ten words at full rate
      load(0, 10);
      m_tready = 1'b1;
      en = 1'b1;
      tick(1);
      chk("t1_first_re", 32'(fifo_re), 32'd1);
      tick(2);
      chk("t1_first_valid", 32'(m_tvalid), 32'd1);
      chk("t1_first_data", 32'(m_tdata), 32'd0);
      wait_out(10, 40, "t1");
      chk_log("t1_data", 0, 0, 10);
      if (out_cyc.size() >= 10)
         chk("t1_rate", 32'(out_cyc[9] - out_cyc[0]), 32'd9);
      en = 1'b0;
      tick(2);
      chk("t1_busy", 32'(busy), 32'd0);

      // 2: eight words with a toggling sink
      base = out_log.size();
      load(16'h10, 8);
      en = 1'b1;
      k = 0;
      while (out_log.size() < base + 8 && k < 80) begin
         m_tready = ~m_tready;
         tick(1);
         k++;
      end
      chk("t2_beats", 32'(out_log.size() - base), 32'd8);
      chk_log("t2_data", base, 16'h10, 8);
      chk("t2_occ_le3", 32'(max_occ <= 3), 32'd1);
      en = 1'b0;
      m_tready = 1'b1;
      tick(3);

      // 3: stop after five reads, then resume
      base = out_log.size();
      rbase = fr;
      load(16'h100, 20);
      en = 1'b1;
      k = 0;
      while (fr - rbase < 5 && k < 20) begin
         tick(1);
         k++;
      end
      en = 1'b0;
      tick(6);
      chk("t3_reads_le6", 32'(fr - rbase <= 6), 32'd1);
      chk("t3_beats_eq_reads", 32'(out_log.size() - base), 32'(fr - rbase));
      for (int i = 0; i < 4; i++) begin
         chk("t3_re_idle", 32'(fifo_re), 32'd0);
         tick(1);
      end
      en = 1'b1;
      wait_out(base + 20, 60, "t3");
      chk_log("t3_data", base, 16'h100, 20);
      en = 1'b0;
      tick(3);

      // 4: flush with a full buffer and seven words left
      base = out_log.size();
      rbase = fr;
      load(16'h200, 10);
      m_tready = 1'b0;
      en = 1'b1;
      tick(8);
      chk("t4_full_valid", 32'(m_tvalid), 32'd1);
      chk("t4_full_data", 32'(m_tdata), 32'h200);
      chk("t4_fifo_left", 32'(fw - fr), 32'd7);
      flush = 1'b1;
      en = 1'b0;
      tick(1);
      flush = 1'b0;
      chk("t4_drop_valid", 32'(m_tvalid), 32'd0);
      seen = 1'b0;
      k = 0;
      while (!seen && k < 20) begin
         tick(1);
         k++;
         if (flush_done) seen = 1'b1;
      end
      chk("t4_flush_done_seen", 32'(seen), 32'd1);
      chk("t4_fifo_empty", 32'(fifo_empty), 32'd1);
      chk("t4_reads", 32'(fr - rbase), 32'd10);
      tick(1);
      chk("t4_done_pulse", 32'(flush_done), 32'd0);
      chk("t4_idle", 32'(busy), 32'd0);
      m_tready = 1'b1;
      tick(3);
      chk("t4_no_beats", 32'(out_log.size() - base), 32'd0);

      // 5: reset with two words buffered
      load(16'h300, 2);
      m_tready = 1'b0;
      en = 1'b1;
      tick(6);
      chk("t5_pre_valid", 32'(m_tvalid), 32'd1);
      chk("t5_pre_data", 32'(m_tdata), 32'h300);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(m_tvalid), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      chk("t5_async_re", 32'(fifo_re), 32'd0);
      base = out_log.size();
      load(16'h310, 3);
      tick(3);
      rst_n = 1'b1;
      m_tready = 1'b1;
      wait_out(base + 3, 30, "t5");
      chk_log("t5_data", base, 16'h310, 3);
      en = 1'b0;
      tick(3);

`ifdef FIFO_READER_TLAST_EN
      // 6: three packets of four beats
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      k = last_idx.size();
      base = out_log.size();
      load(16'h400, 12);
      en = 1'b1;
      wait_out(base + 12, 50, "t6");
      chk_log("t6_data", base, 16'h400, 12);
      chk("t6_nlast", 32'(last_idx.size() - k), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (k + i < last_idx.size())
            chk("t6_last_idx", 32'(last_idx[k + i]), 32'(4 * i + 3));
      end
      en = 1'b0;
      tick(2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
